bram_arbiter: RTL and testbench

- Shares the single 3-channel image BRAM between two requesters: the SPI data-transfer side (com) and the image-processing side (pdi).
- Grants whole bursts with round-robin fairness and enforces a burst limit.
- Inserts one turnaround cycle between owners.
- Routes read data back to whichever requester issued the read, even across grant switches.
- Sits between data_transfer_controller / img_processing and bram_controller, replacing ad-hoc pdi_active muxing.

---
 rtl/bram_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_bram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//   Shares the single 3-channel image BRAM between the SPI transfer side (com)
//   and the image-processing side (pdi). Whole bursts are granted round-robin,
//   a burst is capped at MAX_BURST accesses while the other side waits, one
//   turnaround cycle separates owners, and read data is routed back to the
//   side that issued the read even after ownership has moved on.
//
// Optional feature (macro BRAM_ARB_STATS_EN):
//   adds stats_clr input and com_cnt/pdi_cnt saturating access counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   com_* / pdi_*       requester side: req (held for burst), valid, we,
//                       addr, channel, wdata in; gnt, rvalid, rdata out
//   bram_addr/channel/we/wdata  drive to bram_controller
//   bram_rdata          read data from bram_controller
//   owner               00 none, 01 com, 10 pdi
//   stats_clr, com_cnt, pdi_cnt   (BRAM_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module bram_arbiter #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              com_req,
    input  logic              com_valid,
    input  logic              com_we,
    input  logic [ADDR_W-1:0] com_addr,
    input  logic [1:0]        com_channel,
    input  logic [DATA_W-1:0] com_wdata,
    output logic              com_gnt,
    output logic              com_rvalid,
    output logic [DATA_W-1:0] com_rdata,

    input  logic              pdi_req,
    input  logic              pdi_valid,
    input  logic              pdi_we,
    input  logic [ADDR_W-1:0] pdi_addr,
    input  logic [1:0]        pdi_channel,
    input  logic [DATA_W-1:0] pdi_wdata,
    output logic              pdi_gnt,
    output logic              pdi_rvalid,
    output logic [DATA_W-1:0] pdi_rdata,

    output logic [ADDR_W-1:0] bram_addr,
    output logic [1:0]        bram_channel,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,

    output logic [1:0]        owner
`ifdef BRAM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       com_cnt,
    output logic [15:0]       pdi_cnt
`endif
);

    localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned RL_W   = READ_LATENCY;
    localparam int unsigned RL_TOP = READ_LATENCY - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_COM = 2'd1,
        OWN_PDI = 2'd2,
        TURN    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_pdi;        // 1: pdi held the last grant
    logic              last_pdi_nxt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  burst_cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;

    logic              own_req;
    logic              own_valid;
    logic              other_req;

    logic              com_acc;
    logic              pdi_acc;
    logic              rd_acc;

    logic [RL_W-1:0]   rd_live;
    logic [RL_W-1:0]   rd_side;         // 1: tag belongs to pdi

    logic [ADDR_W-1:0] hold_addr;
    logic [1:0]        hold_channel;
    logic [DATA_W-1:0] hold_wdata;

    logic [DATA_W-1:0] com_rdata_q;
    logic [DATA_W-1:0] pdi_rdata_q;

    // A granted cycle with valid high is exactly one BRAM access.
    assign com_acc = com_gnt & com_valid;
    assign pdi_acc = pdi_gnt & pdi_valid;
    assign rd_acc  = (com_acc & ~com_we) | (pdi_acc & ~pdi_we);

    // Next-state, round-robin arbitration and burst accounting.
    always_comb begin
        state_nxt     = state;
        last_pdi_nxt  = last_pdi;
        burst_cnt_nxt = burst_cnt;
        cnt_inc       = burst_cnt + CNT_W'(1);
        own_req       = 1'b0;
        own_valid     = 1'b0;
        other_req     = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the side that did not own last wins.
                if (com_req && (!pdi_req || last_pdi)) begin
                    state_nxt = OWN_COM;
                end else if (pdi_req) begin
                    state_nxt = OWN_PDI;
                end
            end

            OWN_COM, OWN_PDI: begin
                own_req   = (state == OWN_PDI) ? pdi_req   : com_req;
                own_valid = (state == OWN_PDI) ? pdi_valid : com_valid;
                other_req = (state == OWN_PDI) ? com_req   : pdi_req;

                if (own_valid) begin
                    burst_cnt_nxt = cnt_inc;
                end

                if (!own_req) begin
                    state_nxt     = TURN;
                    last_pdi_nxt  = (state == OWN_PDI);
                    burst_cnt_nxt = '0;
                end else if (own_valid && (cnt_inc == CNT_W'(MAX_BURST))) begin
                    // Burst limit reached: yield only if the other side waits.
                    burst_cnt_nxt = '0;
                    if (other_req) begin
                        state_nxt    = TURN;
                        last_pdi_nxt = (state == OWN_PDI);
                    end
                end
            end

            TURN: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; grants and owner are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_pdi  <= 1'b1;
            burst_cnt <= '0;
            com_gnt   <= 1'b0;
            pdi_gnt   <= 1'b0;
            owner     <= 2'b00;
        end else begin
            state     <= state_nxt;
            last_pdi  <= last_pdi_nxt;
            burst_cnt <= burst_cnt_nxt;
            com_gnt   <= (state_nxt == OWN_COM);
            pdi_gnt   <= (state_nxt == OWN_PDI);
            owner     <= {state_nxt == OWN_PDI, state_nxt == OWN_COM};
        end
    end

    // BRAM drive follows the current owner; with no owner the last values hold.
    always_comb begin
        bram_addr    = hold_addr;
        bram_channel = hold_channel;
        bram_wdata   = hold_wdata;
        if (com_gnt) begin
            bram_addr    = com_addr;
            bram_channel = com_channel;
            bram_wdata   = com_wdata;
        end else if (pdi_gnt) begin
            bram_addr    = pdi_addr;
            bram_channel = pdi_channel;
            bram_wdata   = pdi_wdata;
        end
    end

    assign bram_we = (com_acc & com_we) | (pdi_acc & pdi_we);

    // Remember the last owned drive values for the unowned cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr    <= '0;
            hold_channel <= '0;
            hold_wdata   <= '0;
        end else if (com_gnt || pdi_gnt) begin
            hold_addr    <= bram_addr;
            hold_channel <= bram_channel;
            hold_wdata   <= bram_wdata;
        end
    end

    // Read-return tag pipe; bit 0 is the newest access, bit RL_TOP lines up
    // with the BRAM data. Tags are independent of later grant changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_live <= '0;
            rd_side <= '0;
        end else begin
            rd_live <= RL_W'({rd_live, rd_acc});
            rd_side <= RL_W'({rd_side, pdi_acc});
        end
    end

    assign com_rvalid = rd_live[RL_TOP] & ~rd_side[RL_TOP];
    assign pdi_rvalid = rd_live[RL_TOP] &  rd_side[RL_TOP];

    // rdata passes BRAM data in the rvalid cycle and holds otherwise.
    assign com_rdata = com_rvalid ? bram_rdata : com_rdata_q;
    assign pdi_rdata = pdi_rvalid ? bram_rdata : pdi_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            com_rdata_q <= '0;
            pdi_rdata_q <= '0;
        end else begin
            com_rdata_q <= com_rdata;
            pdi_rdata_q <= pdi_rdata;
        end
    end

`ifdef BRAM_ARB_STATS_EN
    // Saturating granted-access counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            com_cnt <= '0;
            pdi_cnt <= '0;
        end else begin
            if (com_acc && (com_cnt != 16'hFFFF)) begin
                com_cnt <= com_cnt + 16'd1;
            end
            if (pdi_acc && (pdi_cnt != 16'hFFFF)) begin
                pdi_cnt <= pdi_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
//   Self-checking bench for bram_arbiter (READ_LATENCY=3, MAX_BURST=4) with a
//   behavioural BRAM. Expected reads are queued when issued and compared
//   (side, data, arrival cycle) when rvalid appears.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RL     = 3;
    localparam int unsigned MB     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              com_req = 1'b0, com_valid = 1'b0, com_we = 1'b0;
    logic [ADDR_W-1:0] com_addr = '0;
    logic [1:0]        com_channel = '0;
    logic [DATA_W-1:0] com_wdata = '0;
    logic              com_gnt, com_rvalid;
    logic [DATA_W-1:0] com_rdata;
    logic              pdi_req = 1'b0, pdi_valid = 1'b0, pdi_we = 1'b0;
    logic [ADDR_W-1:0] pdi_addr = '0;
    logic [1:0]        pdi_channel = '0;
    logic [DATA_W-1:0] pdi_wdata = '0;
    logic              pdi_gnt, pdi_rvalid;
    logic [DATA_W-1:0] pdi_rdata;
    logic [ADDR_W-1:0] bram_addr;
    logic [1:0]        bram_channel;
    logic              bram_we;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic [1:0]        owner;
`ifdef BRAM_ARB_STATS_EN
    logic              stats_clr = 1'b0;
    logic [15:0]       com_cnt, pdi_cnt;
`endif

    bram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .com_req(com_req), .com_valid(com_valid), .com_we(com_we),
        .com_addr(com_addr), .com_channel(com_channel), .com_wdata(com_wdata),
        .com_gnt(com_gnt), .com_rvalid(com_rvalid), .com_rdata(com_rdata),
        .pdi_req(pdi_req), .pdi_valid(pdi_valid), .pdi_we(pdi_we),
        .pdi_addr(pdi_addr), .pdi_channel(pdi_channel), .pdi_wdata(pdi_wdata),
        .pdi_gnt(pdi_gnt), .pdi_rvalid(pdi_rvalid), .pdi_rdata(pdi_rdata),
        .bram_addr(bram_addr), .bram_channel(bram_channel), .bram_we(bram_we),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .owner(owner)
`ifdef BRAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .com_cnt(com_cnt), .pdi_cnt(pdi_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural BRAM with RL-cycle read latency.
    logic [DATA_W-1:0] bram_mem [0:1023];
    logic [DATA_W-1:0] exp_mem  [0:1023];
    logic [DATA_W-1:0] rd_pipe  [0:RL-1];

    function automatic int midx(input logic [ADDR_W-1:0] a, input logic [1:0] ch);
        return int'({ch, a[7:0]});
    endfunction

    always @(posedge clk) begin
        if (bram_we) bram_mem[midx(bram_addr, bram_channel)] <= bram_wdata;
        rd_pipe[0] <= bram_mem[midx(bram_addr, bram_channel)];
        for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rdata = rd_pipe[RL-1];

    // Scoreboard and bookkeeping.
    typedef struct {
        logic              side;
        logic [DATA_W-1:0] data;
        int unsigned       due;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    int unsigned       cyc = 0;
    int                total = 0;
    int                bad = 0;
    logic              mon_off = 1'b1;
    logic [DATA_W-1:0] last_com = '0;
    logic [DATA_W-1:0] last_pdi = '0;
    int                we_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read-return monitor.
    always @(negedge clk) begin
        if (!mon_off) begin
            if (com_rvalid || pdi_rvalid) begin
                check("rv_both", 32'(com_rvalid & pdi_rvalid), 32'd0);
                if (sb.size() == 0) begin
                    check("rv_unexpected", 32'({com_rvalid, pdi_rvalid}), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rv_side", 32'(pdi_rvalid), 32'(mon_e.side));
                    check("rv_due", cyc, mon_e.due);
                    if (mon_e.side) begin
                        check("pdi_rdata", 32'(pdi_rdata), 32'(mon_e.data));
                        last_pdi = mon_e.data;
                    end else begin
                        check("com_rdata", 32'(com_rdata), 32'(mon_e.data));
                        last_com = mon_e.data;
                    end
                end
            end
            if (!com_rvalid) check("com_hold", 32'(com_rdata), 32'(last_com));
            if (!pdi_rvalid) check("pdi_hold", 32'(pdi_rdata), 32'(last_pdi));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_valid();
        com_valid = 1'b0; com_we = 1'b0;
        pdi_valid = 1'b0; pdi_we = 1'b0;
    endtask

    // One access by a side the bench knows is granted this cycle.
    task automatic acc(input logic side, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [1:0] ch, input logic [DATA_W-1:0] wd);
        exp_t e;
        idle_valid();
        if (side) begin
            pdi_valid = 1'b1; pdi_we = we; pdi_addr = a; pdi_channel = ch; pdi_wdata = wd;
        end else begin
            com_valid = 1'b1; com_we = we; com_addr = a; com_channel = ch; com_wdata = wd;
        end
        if (we) begin
            exp_mem[midx(a, ch)] = wd;
        end else begin
            e.side = side;
            e.data = exp_mem[midx(a, ch)];
            e.due  = cyc + RL;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        mon_off = 1'b1;
        rst = 1'b1;
        com_req = 1'b0; pdi_req = 1'b0;
        idle_valid();
        repeat (n) step();
        rst = 1'b0;
        sb.delete();
        last_com = '0;
        last_pdi = '0;
        mon_off = 1'b0;
    endtask

    task automatic drain();
        com_req = 1'b0; pdi_req = 1'b0;
        idle_valid();
        repeat (RL + 3) step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram_mem[i] = 8'(i * 37 + 11);
            exp_mem[i]  = 8'(i * 37 + 11);
        end
        bram_mem[midx(17'h00010, 2'd1)] = 8'hA5;
        exp_mem[midx(17'h00010, 2'd1)]  = 8'hA5;

        // Reset values.
        do_reset(2);
        mid();
        check("rst_com_gnt", 32'(com_gnt), 32'd0);
        check("rst_pdi_gnt", 32'(pdi_gnt), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_bram_we", 32'(bram_we), 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_bram_ch", 32'(bram_channel), 32'd0);
        check("rst_bram_wdata", 32'(bram_wdata), 32'd0);

        // Single com request, reads back-to-back, write then read back.
        step(); com_req = 1'b1;
        mid();  check("t1_gnt_latency", 32'(com_gnt), 32'd0);
        step(); acc(1'b0, 1'b0, 17'h00010, 2'd1, 8'h00);
        mid();
        check("t1_com_gnt", 32'(com_gnt), 32'd1);
        check("t1_pdi_gnt", 32'(pdi_gnt), 32'd0);
        check("t1_owner", 32'(owner), 32'd1);
        check("t1_bram_addr", 32'(bram_addr), 32'h10);
        check("t1_bram_ch", 32'(bram_channel), 32'd1);
        check("t1_bram_we_rd", 32'(bram_we), 32'd0);
        step(); acc(1'b0, 1'b0, 17'h00011, 2'd0, 8'h00);
        step(); acc(1'b0, 1'b0, 17'h00012, 2'd2, 8'h00);
        step(); acc(1'b0, 1'b1, 17'h00013, 2'd0, 8'h5A);
        mid();
        check("t1_bram_we_wr", 32'(bram_we), 32'd1);
        check("t1_bram_wdata", 32'(bram_wdata), 32'h5A);
        step(); acc(1'b0, 1'b0, 17'h00013, 2'd0, 8'h00);
        step(); idle_valid(); com_req = 1'b0;
        step();
        // TURN: unowned drive holds, ungranted valid is ignored.
        com_addr = 17'h00055; com_valid = 1'b1; com_we = 1'b1;
        mid();
        check("t1_turn_gnt", 32'(com_gnt), 32'd0);
        check("t1_hold_addr", 32'(bram_addr), 32'h13);
        check("t1_nognt_we", 32'(bram_we), 32'd0);
        drain();

        // Tie after reset: com first, turnaround, then pdi, then com again.
        do_reset(1);
        step(); com_req = 1'b1; pdi_req = 1'b1;
        step();
        mid();
        check("t2_tie_com", 32'(com_gnt), 32'd1);
        check("t2_tie_pdi", 32'(pdi_gnt), 32'd0);
        step(); com_req = 1'b0;
        step();
        mid();
        check("t2_turn_gnt", 32'({com_gnt, pdi_gnt}), 32'd0);
        check("t2_turn_owner", 32'(owner), 32'd0);
        step();
        mid();
        check("t2_idle_gnt", 32'({com_gnt, pdi_gnt}), 32'd0);
        step(); acc(1'b1, 1'b0, 17'h00010, 2'd1, 8'h00);
        mid();
        check("t2_pdi_gnt", 32'(pdi_gnt), 32'd1);
        check("t2_pdi_owner", 32'(owner), 32'd2);
        step(); idle_valid(); pdi_req = 1'b0;
        step();
        step(); com_req = 1'b1; pdi_req = 1'b1;
        step();
        mid();
        check("t2_rr_com", 32'(com_gnt), 32'd1);
        check("t2_rr_pdi", 32'(pdi_gnt), 32'd0);
        drain();

        // Preemption: pdi streams writes while com waits.
        do_reset(1);
        step(); pdi_req = 1'b1;
        we_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) com_req = 1'b1;
            if (k < int'(MB)) begin
                acc(1'b1, 1'b1, 17'(32'h20 + k), 2'd0, 8'(32'h30 + k));
            end else begin
                pdi_valid = 1'b1; pdi_we = 1'b1;
                pdi_addr = 17'(32'h20 + k); pdi_wdata = 8'(32'h30 + k);
            end
            mid();
            if (bram_we) we_cnt++;
            check("t3_pdi_gnt", 32'(pdi_gnt), 32'(k < int'(MB)));
            check("t3_com_gnt", 32'(com_gnt), 32'(k >= int'(MB) + 2));
        end
        check("t3_we_pulses", 32'(we_cnt), 32'(MB));
        drain();

        // pdi alone keeps the grant past the burst limit.
        do_reset(1);
        step(); pdi_req = 1'b1;
        we_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(); acc(1'b1, 1'b1, 17'(32'h40 + k), 2'd0, 8'(32'h60 + k));
            mid();
            if (bram_we) we_cnt++;
            check("t3b_pdi_gnt", 32'(pdi_gnt), 32'd1);
        end
        check("t3b_we_pulses", 32'(we_cnt), 32'd10);
        step(); acc(1'b1, 1'b0, 17'h00044, 2'd0, 8'h00);
        drain();

        // Read in pdi's last burst cycle returns to pdi while com owns.
        do_reset(1);
        step(); pdi_req = 1'b1;
        step(); com_req = 1'b1; acc(1'b1, 1'b1, 17'h00070, 2'd2, 8'hC3);
        step(); acc(1'b1, 1'b1, 17'h00071, 2'd2, 8'hC4);
        step(); acc(1'b1, 1'b1, 17'h00072, 2'd2, 8'hC5);
        step(); acc(1'b1, 1'b0, 17'h00070, 2'd2, 8'h00);
        step(); idle_valid(); pdi_req = 1'b0;
        mid();  check("t4_turn_pdi_gnt", 32'(pdi_gnt), 32'd0);
        step();
        step(); acc(1'b0, 1'b0, 17'h00010, 2'd1, 8'h00);
        mid();
        check("t4_com_gnt", 32'(com_gnt), 32'd1);
        check("t4_pdi_rvalid", 32'(pdi_rvalid), 32'd1);
        check("t4_com_rvalid", 32'(com_rvalid), 32'd0);
        drain();

        // Reset with two reads in flight.
        do_reset(1);
        step(); com_req = 1'b1;
        step(); acc(1'b0, 1'b0, 17'h00010, 2'd1, 8'h00);
        step(); acc(1'b0, 1'b0, 17'h00011, 2'd0, 8'h00);
        step(); do_reset(1);
        mid();
        check("t5_gnt", 32'({com_gnt, pdi_gnt}), 32'd0);
        check("t5_owner", 32'(owner), 32'd0);
        check("t5_bram_we", 32'(bram_we), 32'd0);
        check("t5_rvalid", 32'({com_rvalid, pdi_rvalid}), 32'd0);
        check("t5_rdata", 32'(com_rdata), 32'd0);
        step();
        mid();
        check("t5_rvalid_late", 32'({com_rvalid, pdi_rvalid}), 32'd0);
        drain();

`ifdef BRAM_ARB_STATS_EN
        // Access statistics and clear priority.
        do_reset(1);
        step(); com_req = 1'b1;
        step(); acc(1'b0, 1'b1, 17'h00080, 2'd0, 8'h01);
        step(); acc(1'b0, 1'b1, 17'h00081, 2'd0, 8'h02);
        step(); acc(1'b0, 1'b1, 17'h00082, 2'd0, 8'h03);
        step(); idle_valid(); com_req = 1'b0; pdi_req = 1'b1;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            step(); acc(1'b1, 1'b1, 17'(32'h90 + k), 2'd1, 8'(k));
        end
        step(); idle_valid();
        mid();
        check("st_com_cnt", 32'(com_cnt), 32'd3);
        check("st_pdi_cnt", 32'(pdi_cnt), 32'd5);
        step(); acc(1'b1, 1'b1, 17'h00095, 2'd1, 8'h09); stats_clr = 1'b1;
        step(); idle_valid(); stats_clr = 1'b0;
        mid();
        check("st_clr_pdi", 32'(pdi_cnt), 32'd0);
        check("st_clr_com", 32'(com_cnt), 32'd0);
        drain();
`endif

        repeat (RL + 2) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
